// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: counter states,
// entry layout and the PC index/tag split.
package bp_pkg;

  // Counter states, derived from the counter width.
  function automatic int unsigned cnt_strong_nt(input int unsigned w);
    return 0;
  endfunction

  function automatic int unsigned cnt_weak_nt(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int unsigned cnt_weak_taken(input int unsigned w);
    return 1 << (w - 1);
  endfunction

  function automatic int unsigned cnt_strong_taken(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  // Entry layout at the default configuration (32-bit PC, 64 entries, 2-bit counter).
  localparam int unsigned BP_DATA_W = 32;
  localparam int unsigned BP_IDX_W  = 6;
  localparam int unsigned BP_TAG_W  = BP_DATA_W - BP_IDX_W - 2;
  localparam int unsigned BP_CNT_W  = 2;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_DATA_W-1:0] target;
    logic [BP_CNT_W-1:0]  cnt;
  } bp_entry_t;

  // Index = PC[idx_w+1:2], tag = PC[top:idx_w+2]; callers size-cast the result.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational next-value logic for a saturating up/down counter with load.
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (load) begin
      cnt_o = load_val;
    end else if (inc && (cnt_i != '1)) begin
      cnt_o = cnt_i + W'(1);
    end else if (dec && (cnt_i != '0)) begin
      cnt_o = cnt_i - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch target buffer with saturating counters, combinational
// fetch lookup, execute-stage update, mispredict detection and a mispredict counter.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENTRIES    = 64,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PCF,
  output logic                  PredTakenF,
  output logic [DATA_WIDTH-1:0] PredTargetF,
  input  logic                  UpdateE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic                  TakenE,
  input  logic [DATA_WIDTH-1:0] TargetE,
  input  logic                  PredTakenE,
  input  logic [DATA_WIDTH-1:0] PredTargetE,
  output logic                  MispredictE,
  output logic [DATA_WIDTH-1:0] RecoverPCE,
  output logic [STAT_WIDTH-1:0] MispredictCount
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = DATA_WIDTH - IDX - 2;
  localparam logic [CNT_WIDTH-1:0] CNT_WNT = CNT_WIDTH'(cnt_weak_nt(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_WT  = CNT_WIDTH'(cnt_weak_taken(CNT_WIDTH));

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] target;
    logic [CNT_WIDTH-1:0]  cnt;
  } entry_t;

  entry_t table_q [ENTRIES];
  entry_t table_d [ENTRIES];

  logic [STAT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

  logic [IDX-1:0]        f_idx, e_idx;
  logic [TAG_W-1:0]      f_tag, e_tag;
  logic                  hit_f, hit_e;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [DATA_WIDTH-1:0] pcf_plus4, pce_plus4;

  assign f_idx = IDX'(pc_index(64'(PCF), IDX));
  assign f_tag = TAG_W'(pc_tag(64'(PCF), IDX));
  assign e_idx = IDX'(pc_index(64'(PCE), IDX));
  assign e_tag = TAG_W'(pc_tag(64'(PCE), IDX));

  assign pcf_plus4 = PCF + DATA_WIDTH'(4);
  assign pce_plus4 = PCE + DATA_WIDTH'(4);

  // Lookup reads the registered table only, so same-cycle updates are not bypassed.
  assign hit_f       = table_q[f_idx].valid && (table_q[f_idx].tag == f_tag);
  assign PredTakenF  = hit_f && table_q[f_idx].cnt[CNT_WIDTH-1];
  assign PredTargetF = PredTakenF ? table_q[f_idx].target : pcf_plus4;

  assign hit_e = table_q[e_idx].valid && (table_q[e_idx].tag == e_tag);

  assign MispredictE = UpdateE && ((TakenE != PredTakenE) ||
                                   (TakenE && PredTakenE && (TargetE != PredTargetE)));
  assign RecoverPCE  = (UpdateE && TakenE) ? TargetE : pce_plus4;

  // A miss only ever writes on allocation, which loads the weakly-taken state.
  sat_counter #(.W(CNT_WIDTH)) u_sat_counter (
    .cnt_i    (table_q[e_idx].cnt),
    .inc      (TakenE),
    .dec      (!TakenE),
    .load     (!hit_e),
    .load_val (CNT_WT),
    .cnt_o    (cnt_next)
  );

  always_comb begin
    table_d = table_q;
    if (UpdateE) begin
      if (hit_e) begin
        table_d[e_idx].cnt = cnt_next;
        if (TakenE) begin
          table_d[e_idx].target = TargetE;
        end
      end else if (TakenE) begin
        table_d[e_idx].valid  = 1'b1;
        table_d[e_idx].tag    = e_tag;
        table_d[e_idx].target = TargetE;
        table_d[e_idx].cnt    = cnt_next;
      end
    end
  end

  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (MispredictE && (mis_cnt_q != '1)) begin
      mis_cnt_d = mis_cnt_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
        table_q[i].cnt   <= CNT_WNT;
      end
      mis_cnt_q <= '0;
    end else begin
      table_q   <= table_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; a second instance with a
// 2-bit statistics counter checks mispredict-count saturation.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE;
  logic [31:0] PCE;
  logic        TakenE;
  logic [31:0] TargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RecoverPCE;
  logic [15:0] MispredictCount;

  logic        s_PredTakenF;
  logic [31:0] s_PredTargetF;
  logic        s_MispredictE;
  logic [31:0] s_RecoverPCE;
  logic [1:0]  s_MispredictCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.DATA_WIDTH(32), .ENTRIES(64), .CNT_WIDTH(2), .STAT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .RecoverPCE(RecoverPCE), .MispredictCount(MispredictCount)
  );

  branch_predictor #(.DATA_WIDTH(32), .ENTRIES(64), .CNT_WIDTH(2), .STAT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(s_PredTakenF), .PredTargetF(s_PredTargetF),
    .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(s_MispredictE),
    .RecoverPCE(s_RecoverPCE), .MispredictCount(s_MispredictCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_update(input logic [31:0] pce, input logic taken, input logic [31:0] tgt,
                            input logic ptaken, input logic [31:0] ptgt);
    UpdateE     = 1'b1;
    PCE         = pce;
    TakenE      = taken;
    TargetE     = tgt;
    PredTakenE  = ptaken;
    PredTargetE = ptgt;
  endtask

  task automatic clear_update();
    UpdateE = 1'b0;
    TakenE = 1'b0;
    PredTakenE = 1'b0;
  endtask

  task automatic test_reset();
    PCF = 32'h100;
    rst = 1'b1;
    set_update(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    tick();
    rst = 1'b0;
    clear_update();
    #1;
    checks++;
    if (PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", PredTakenF); end
    checks++;
    if (PredTargetF !== 32'h104) begin errors++; $display("FAIL reset_pred_target: got %h expected 00000104", PredTargetF); end
    checks++;
    if (MispredictCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", MispredictCount); end
  endtask

  task automatic test_allocate();
    PCF = 32'h100;
    set_update(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    checks++;
    if (MispredictE !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %b expected 1", MispredictE); end
    checks++;
    if (RecoverPCE !== 32'h80) begin errors++; $display("FAIL alloc_recover: got %h expected 00000080", RecoverPCE); end
    checks++;
    if (PredTakenF !== 1'b0) begin errors++; $display("FAIL alloc_no_bypass: got %b expected 0", PredTakenF); end
    tick();
    clear_update();
    #1;
    checks++;
    if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %b expected 1", PredTakenF); end
    checks++;
    if (PredTargetF !== 32'h80) begin errors++; $display("FAIL alloc_pred_target: got %h expected 00000080", PredTargetF); end
    checks++;
    if (MispredictCount !== 16'd1) begin errors++; $display("FAIL alloc_count: got %0d expected 1", MispredictCount); end
  endtask

  task automatic test_counter_saturate();
    PCF = 32'h100;
    set_update(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    tick();
    clear_update();
    #1;
    checks++;
    if (PredTakenF !== 1'b0) begin errors++; $display("FAIL cnt_after_first_nt: got %b expected 0", PredTakenF); end
    checks++;
    if (PredTargetF !== 32'h104) begin errors++; $display("FAIL cnt_target_nt: got %h expected 00000104", PredTargetF); end
    for (int i = 0; i < 2; i++) begin
      set_update(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
      tick();
    end
    set_update(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    clear_update();
    #1;
    checks++;
    if (PredTakenF !== 1'b0) begin errors++; $display("FAIL cnt_after_one_taken: got %b expected 0", PredTakenF); end
    set_update(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    #1;
    checks++;
    if (MispredictE !== 1'b0) begin errors++; $display("FAIL cnt_correct_taken: got %b expected 0", MispredictE); end
    tick();
    clear_update();
    #1;
    checks++;
    if (PredTakenF !== 1'b1) begin errors++; $display("FAIL cnt_after_two_taken: got %b expected 1", PredTakenF); end
    checks++;
    if (MispredictCount !== 16'd2) begin errors++; $display("FAIL cnt_count: got %0d expected 2", MispredictCount); end
  endtask

  task automatic test_alias();
    set_update(32'h200, 1'b1, 32'h500, 1'b0, 32'h204);
    tick();
    clear_update();
    PCF = 32'h100;
    #1;
    checks++;
    if (PredTakenF !== 1'b0) begin errors++; $display("FAIL alias_old_taken: got %b expected 0", PredTakenF); end
    checks++;
    if (PredTargetF !== 32'h104) begin errors++; $display("FAIL alias_old_target: got %h expected 00000104", PredTargetF); end
    PCF = 32'h200;
    #1;
    checks++;
    if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alias_new_taken: got %b expected 1", PredTakenF); end
    checks++;
    if (PredTargetF !== 32'h500) begin errors++; $display("FAIL alias_new_target: got %h expected 00000500", PredTargetF); end
  endtask

  task automatic test_jalr();
    PCF = 32'h40;
    set_update(32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
    tick();
    clear_update();
    #1;
    checks++;
    if (PredTargetF !== 32'h300) begin errors++; $display("FAIL jalr_first_target: got %h expected 00000300", PredTargetF); end
    set_update(32'h40, 1'b1, 32'h340, 1'b1, 32'h300);
    #1;
    checks++;
    if (MispredictE !== 1'b1) begin errors++; $display("FAIL jalr_mispredict: got %b expected 1", MispredictE); end
    checks++;
    if (RecoverPCE !== 32'h340) begin errors++; $display("FAIL jalr_recover: got %h expected 00000340", RecoverPCE); end
    tick();
    clear_update();
    #1;
    checks++;
    if (PredTargetF !== 32'h340) begin errors++; $display("FAIL jalr_new_target: got %h expected 00000340", PredTargetF); end
    checks++;
    if (MispredictCount !== 16'd5) begin errors++; $display("FAIL jalr_count: got %0d expected 5", MispredictCount); end
  endtask

  task automatic test_wrap();
    PCF = 32'hFFFF_FFFC;
    set_update(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (RecoverPCE !== 32'h0) begin errors++; $display("FAIL wrap_recover: got %h expected 00000000", RecoverPCE); end
    checks++;
    if (MispredictE !== 1'b0) begin errors++; $display("FAIL wrap_mispredict: got %b expected 0", MispredictE); end
    checks++;
    if (PredTargetF !== 32'h0) begin errors++; $display("FAIL wrap_pred_target: got %h expected 00000000", PredTargetF); end
    tick();
    UpdateE = 1'b0;
    TakenE = 1'b1;
    PredTakenE = 1'b0;
    #1;
    checks++;
    if (MispredictE !== 1'b0) begin errors++; $display("FAIL no_update_mispredict: got %b expected 0", MispredictE); end
    tick();
    clear_update();
    #1;
    checks++;
    if (MispredictCount !== 16'd5) begin errors++; $display("FAIL no_update_count: got %0d expected 5", MispredictCount); end
  endtask

  task automatic test_stat_saturate();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (s_MispredictCount !== 2'd0) begin errors++; $display("FAIL stat_reset: got %0d expected 0", s_MispredictCount); end
    for (int i = 0; i < 5; i++) begin
      set_update(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      tick();
    end
    clear_update();
    #1;
    checks++;
    if (s_MispredictCount !== 2'd3) begin errors++; $display("FAIL stat_saturate: got %0d expected 3", s_MispredictCount); end
    checks++;
    if (MispredictCount !== 16'd5) begin errors++; $display("FAIL stat_wide_count: got %0d expected 5", MispredictCount); end
  endtask

  task automatic test_reset_during_op();
    PCF = 32'h100;
    #1;
    checks++;
    if (PredTakenF !== 1'b1) begin errors++; $display("FAIL rst_op_pre_taken: got %b expected 1", PredTakenF); end
    rst = 1'b1;
    set_update(32'h100, 1'b1, 32'h90, 1'b0, 32'h104);
    tick();
    rst = 1'b0;
    clear_update();
    #1;
    checks++;
    if (PredTakenF !== 1'b0) begin errors++; $display("FAIL rst_op_taken: got %b expected 0", PredTakenF); end
    checks++;
    if (PredTargetF !== 32'h104) begin errors++; $display("FAIL rst_op_target: got %h expected 00000104", PredTargetF); end
    checks++;
    if (MispredictCount !== 16'd0) begin errors++; $display("FAIL rst_op_count: got %0d expected 0", MispredictCount); end
    set_update(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    tick();
    clear_update();
    #1;
    checks++;
    if (PredTakenF !== 1'b0) begin errors++; $display("FAIL rst_op_nt_no_alloc: got %b expected 0", PredTakenF); end
  endtask

  initial begin
    rst = 1'b0;
    PCF = '0;
    PCE = '0;
    TargetE = '0;
    PredTargetE = '0;
    clear_update();
    #1;
    test_reset();
    test_allocate();
    test_counter_saturate();
    test_alias();
    test_jalr();
    test_wrap();
    test_stat_saturate();
    test_reset_during_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipeline. It is looked up combinationally with the fetch PC, so that instruction fetch can redirect to a predicted target. It is updated from the execute stage when a branch or jump resolves. It replaces the static "predict not-taken, flush on taken" scheme by producing a mispredict flag and a recovery PC for the hazard unit, and it counts mispredictions for debug.

## Interface
Parameters:
- DATA_WIDTH, 32, PC/target width
- ENTRIES, 64, table depth; power of two, ≥ 2
- CNT_WIDTH, 2, saturating-counter width per entry, ≥ 1
- STAT_WIDTH, 16, mispredict statistics counter width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- PCF  in  DATA_WIDTH  fetch PC for lookup
- PredTakenF  out  1  prediction: taken
- PredTargetF  out  DATA_WIDTH  predicted target; equals PCF+4 when PredTakenF=0
- UpdateE  in  1  a branch, JAL or JALR is resolving in execute this cycle
- PCE  in  DATA_WIDTH  PC of the resolving instruction
- TakenE  in  1  actual outcome
- TargetE  in  DATA_WIDTH  actual target (PCTarget or JALR result)
- PredTakenE  in  1  prediction made for this instruction, piped from fetch
- PredTargetE  in  DATA_WIDTH  predicted target, piped from fetch
- MispredictE  out  1  redirect required; this replaces PCSrcE at the hazard unit
- RecoverPCE  out  DATA_WIDTH  correct next PC when MispredictE=1
- MispredictCount  out  STAT_WIDTH  saturating count of mispredictions

## Operation
- Index = PC[IDX+1:2], where IDX = log2(ENTRIES). Tag = PC[DATA_WIDTH-1:IDX+2].
- Each entry holds: valid, tag, target (DATA_WIDTH), counter (CNT_WIDTH).
- Lookup (combinational): hit = valid & tag match.
  - PredTakenF = hit & counter MSB.
  - PredTargetF = PredTakenF ? entry target : PCF+4.
- Mispredict (combinational, qualified by UpdateE):
  - MispredictE = UpdateE & ((TakenE != PredTakenE) | (TakenE & PredTakenE & TargetE != PredTargetE)).
  - RecoverPCE = TakenE ? TargetE : PCE+4.
  - When UpdateE=0, MispredictE=0 and RecoverPCE is don't-care; the implementation drives PCE+4.
- Update, on a clock edge with UpdateE=1, at the entry indexed by PCE:
  - On a hit: the counter increments if TakenE, otherwise decrements, saturating at 0 and at 2^CNT_WIDTH-1. The target is overwritten with TargetE when TakenE.
  - On a miss with TakenE=1: allocate. valid=1, tag and target written, counter = 2^(CNT_WIDTH-1) (weakly taken). Any prior entry at that index is replaced.
  - On a miss with TakenE=0: no change.
- MispredictCount increments on each cycle with MispredictE=1 and saturates at all-ones.
- All PC+4 arithmetic is DATA_WIDTH wide and wraps modulo 2^DATA_WIDTH.

## Timing
- Lookup has zero latency: outputs are valid in the same cycle as PCF.
- An update is visible to lookups from the cycle after the edge.
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents. There is no bypass.
- MispredictE and RecoverPCE have zero latency from the E-stage inputs.
- Reset, on an edge with rst=1:
  - All valid bits are cleared, all counters go to 2^(CNT_WIDTH-1)-1 (weakly not-taken), and MispredictCount goes to 0.
  - Targets and tags are not reset.
  - During and after reset, PredTakenF=0 and PredTargetF=PCF+4.
- rst takes priority over a simultaneous UpdateE. A reset during operation discards that update and does not count it.
- Stall and flush are handled externally. The hazard unit must deassert UpdateE for a flushed E stage.

## Structure
- Package bp_pkg holds:
  - the counter-state constants (strong/weak taken/not-taken, derived from CNT_WIDTH);
  - the entry struct typedef (valid, tag, target, counter);
  - a function for the index/tag split.
- Sub-module sat_counter: parametrised by width, with inc/dec/load inputs and saturation. It is instantiated once per entry, or once in the update path, feeding the written value.
- The table is a flop array, not an inferred RAM, because of the combinational read and the reset of valid bits.

## Test plan
- Reset, then PCF=0x100 -> PredTakenF=0 and PredTargetF=0x104. MispredictCount=0.
- Update PCE=0x100, TakenE=1, TargetE=0x80, PredTakenE=0 -> MispredictE=1 and RecoverPCE=0x80. On the next cycle, PCF=0x100 gives PredTakenF=1, PredTargetF=0x80, and MispredictCount=1.
- With CNT_WIDTH=2, issue three not-taken updates to 0x100 after allocation -> the counter goes 10→01→00→00 (saturates). Prediction is not-taken after the first update. Then one taken update gives 01, still not-taken.
- Aliasing with ENTRIES=64: allocate 0x100, then allocate 0x200 (same index, different tag) -> lookup of 0x100 misses and predicts 0x104. Lookup of 0x200 hits.
- JALR target change: entry at 0x40 predicts 0x300. Update with TakenE=1, PredTakenE=1, PredTargetE=0x300, TargetE=0x340 -> MispredictE=1 and RecoverPCE=0x340. The stored target becomes 0x340.
- Edge cases:
  - rst=1 together with UpdateE=1 leaves the table invalid and MispredictCount=0.
  - With STAT_WIDTH=2, five mispredicts leave the count at 3.
  - PCE=0xFFFFFFFC not-taken gives RecoverPCE=0x0.
